systolic_tile_controller: RTL and testbench
===========================================

Name: systolic_tile_controller

Overview:
- Next-generation accelerator controller between the CPU bus slave port and the west/north FIFO banks plus the systolic array.
- Generalises the single-tile flow to multi-pass K-tiling: one MATMUL command accumulates N consecutive K-tiles.
- Adds a readable status word and a row-wise MOVE (output→west FIFO) path with optional ReLU.
- Fully parametrised in array size, data width and maximum pass count.

Parameters:
- DATA_WIDTH, 16, element width in bits.
- ARRAY_SIZE, 16, systolic rows/columns; also FIFO lane count.
- MAX_PASSES, 4, maximum K-tiles per MATMUL command; FIFO depth is ARRAY_SIZE*MAX_PASSES.
- INTRA_ROW_BIT, 5, address bits inside one row packet.
- PACKET_WIDTH, ARRAY_SIZE*DATA_WIDTH, bus packet width.

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- bus_slave_input  in  PACKET_WIDTH  write data
- bus_slave_addr  in  32  request address
- bus_slave_read_request  in  1  read strobe
- bus_slave_write_request  in  1  write strobe
- bus_slave_request_finish  out  1  request completion
- bus_slave_output  out  PACKET_WIDTH  read data (row or status)
- west_fifo_rsts/injects/bubbles  out  ARRAY_SIZE each  west lane control
- north_fifo_rsts/injects/bubbles  out  ARRAY_SIZE each  north lane control
- west_fifo_input_data, north_fifo_input_data  out  PACKET_WIDTH  lane data
- systolic_rst, systolic_accumulate_enable, systolic_read_enable  out  1 each
- systolic_row_index  out  32  row select
- systolic_row_results  in  PACKET_WIDTH  selected row contents

Behaviour:
- Clock is clk; reset is synchronous, active-low, on rst_n (decided).
- Reset: state READY; pass/cycle/row counters 0; matmul_done=move_done=0; all FIFO rsts and systolic_rst high while rst_n=0; all other outputs 0.
- Decode:
  - write with addr<OUTPUT_BUFFER_BASE_ADDR → LOAD;
  - write with addr≥OUTPUT_BUFFER_BASE_ADDR → MATMUL, N=bus_slave_input[7:0];
  - read+write with addr<MOVE_ADDR → RESET;
  - read+write with addr==MOVE_ADDR → MOVE;
  - read with addr==STATUS_ADDR → STATUS;
  - any other read → SAVE.
- Row select = addr[ROW_INDEX_BIT+INTRA_ROW_BIT-1:INTRA_ROW_BIT], where ROW_INDEX_BIT=$clog2(ARRAY_SIZE).
- LOAD/SAVE/RESET/STATUS: finish combinational, same cycle, only in READY. In MATMUL/MOVE, finish=0 and the request is ignored (CPU keeps it held).
- LOAD injects the addressed lane with bus_slave_input. SAVE drives read_enable and row_index, output = row results. RESET targets the west FIFOs, north FIFOs or array by base address.
- STATUS output: bit0 busy, bit1 matmul_done, bit2 move_done, bits[15:8] last effective N; rest 0.
- MATMUL:
  - N=0 becomes 1; N>MAX_PASSES becomes MAX_PASSES.
  - CNT = N*ARRAY_SIZE + 2*ARRAY_SIZE - 2.
  - READY→MATMUL on request when !matmul_done; the cycle counter runs 0..CNT, so MATMUL lasts CNT+1 cycles with accumulate_enable=1.
  - bubbles[i] = (cycle ≥ i) on both banks.
  - At cycle==CNT: →READY and matmul_done=1.
- Done handshake: finish = READY && done && request. On the next edge with request still high, done clears and the request is not restarted. The CPU must drop the request for ≥1 cycle before reissuing.
- MOVE:
  - READY→MOVE when !move_done. row runs 0..ARRAY_SIZE, so MOVE lasts ARRAY_SIZE+1 cycles.
  - For row<ARRAY_SIZE: read_enable=1, row_index=row, west inject[row]=1, west data=row results.
  - At row==ARRAY_SIZE: no inject; →READY and move_done=1.
- Simultaneous events:
  - rst_n=0 dominates everything, including mid-MATMUL/MOVE (abort, no done).
  - Decode priority MATMUL > MOVE > RESET > LOAD > SAVE; only one request type is legal per cycle.

Optional Feature:
- RELU_ON_MOVE_EN defined: during MOVE each DATA_WIDTH element (two's complement) with MSB=1 is replaced by 0 before injection; SAVE path unaffected.
- Undefined: MOVE passes results unmodified.

Decomposition:
- Shared package/defines: address map (INPUT_FIFO_BASE_ADDR, WEIGHT_FIFO_BASE_ADDR, OUTPUT_BUFFER_BASE_ADDR, MOVE_ADDR, new STATUS_ADDR), state encodings READY/MATMUL/MOVE, STATUS bit positions.
- One natural sub-module: move_relu_row, a per-element ReLU over a packet. It is instantiated only under RELU_ON_MOVE_EN.

Test Plan:
- ARRAY_SIZE=4, rst_n=0 mid-MATMUL cycle 5 → next edge READY, status=0, all rsts high during reset.
- LOAD write to WEIGHT_FIFO_BASE_ADDR+2<<5 → north inject=4'b0100, finish same cycle, data passthrough.
- MATMUL N=2 (ARRAY_SIZE=4) → accumulate high exactly 15 cycles, bubbles[3] first at cycle 3; finish while held, done cleared next edge.
- MATMUL N=0 → 11 cycles; N=9 with MAX_PASSES=4 → 23 cycles, status[15:8]=4.
- MOVE with row values {-3,5,…} under RELU_ON_MOVE_EN → injected {0,5,…}; without the macro → {-3,5,…}; 5 cycles busy.
- LOAD issued during MATMUL → finish=0, no inject until READY, then completes.

Source files
------------

// File: rtl/systolic_tile_controller_pkg.sv
// Shared address map, controller state/command encodings and STATUS word layout
// for the systolic tile controller.
package systolic_tile_controller_pkg;

   localparam logic [31:0] INPUT_FIFO_BASE_ADDR    = 32'h0000_0000;
   localparam logic [31:0] WEIGHT_FIFO_BASE_ADDR   = 32'h0000_1000;
   localparam logic [31:0] OUTPUT_BUFFER_BASE_ADDR = 32'h0000_2000;
   localparam logic [31:0] MOVE_ADDR               = 32'h0000_3000;
   localparam logic [31:0] STATUS_ADDR             = 32'h0000_4000;

   localparam int STATUS_BUSY_BIT        = 0;
   localparam int STATUS_MATMUL_DONE_BIT = 1;
   localparam int STATUS_MOVE_DONE_BIT   = 2;
   localparam int STATUS_PASSES_LSB      = 8;

   typedef enum logic [1:0] {
      READY  = 2'd0,
      MATMUL = 2'd1,
      MOVE   = 2'd2
   } state_t;

   typedef enum logic [2:0] {
      CMD_NONE   = 3'd0,
      CMD_LOAD   = 3'd1,
      CMD_SAVE   = 3'd2,
      CMD_RESET  = 3'd3,
      CMD_STATUS = 3'd4,
      CMD_MATMUL = 3'd5,
      CMD_MOVE   = 3'd6
   } cmd_t;

   // Priority order: MATMUL > MOVE > RESET > LOAD > STATUS/SAVE.
   function automatic cmd_t decode_cmd(input logic rd, input logic wr, input logic [31:0] addr);
      if (wr && !rd && addr >= OUTPUT_BUFFER_BASE_ADDR)
         return CMD_MATMUL;
      if (wr && rd && addr == MOVE_ADDR)
         return CMD_MOVE;
      if (wr && rd && addr < MOVE_ADDR)
         return CMD_RESET;
      if (wr && !rd)
         return CMD_LOAD;
      if (rd && !wr && addr == STATUS_ADDR)
         return CMD_STATUS;
      if (rd)
         return CMD_SAVE;
      return CMD_NONE;
   endfunction

   function automatic logic [7:0] clamp_passes(input logic [7:0] n, input int max_passes);
      if (n == 8'd0)
         return 8'd1;
      if (32'(n) > 32'(max_passes))
         return 8'(max_passes);
      return n;
   endfunction

endpackage

// File: rtl/systolic_tile_controller_move_relu_row.sv
// Per-element ReLU over one row packet: negative two's-complement elements become 0.
module move_relu_row #(
   parameter int DATA_WIDTH = 16,
   parameter int ARRAY_SIZE = 16
) (
   input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] row_in,
   output logic [ARRAY_SIZE*DATA_WIDTH-1:0] row_out
);

   genvar gi;
   generate
      for (gi = 0; gi < ARRAY_SIZE; gi++) begin : g_elem
         logic [DATA_WIDTH-1:0] elem;
         assign elem = row_in[gi*DATA_WIDTH +: DATA_WIDTH];
         assign row_out[gi*DATA_WIDTH +: DATA_WIDTH] = elem[DATA_WIDTH-1] ? '0 : elem;
      end
   endgenerate

endmodule

// File: rtl/systolic_tile_controller.sv
// Bus-slave controller for FIFO banks and systolic array with multi-pass MATMUL,
// STATUS read and row MOVE; define RELU_ON_MOVE_EN to clamp negatives during MOVE.
module systolic_tile_controller
   import systolic_tile_controller_pkg::*;
#(
   parameter int DATA_WIDTH    = 16,
   parameter int ARRAY_SIZE    = 16,
   parameter int MAX_PASSES    = 4,
   parameter int INTRA_ROW_BIT = 5,
   parameter int PACKET_WIDTH  = ARRAY_SIZE * DATA_WIDTH
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [PACKET_WIDTH-1:0] bus_slave_input,
   input  logic [31:0]             bus_slave_addr,
   input  logic                    bus_slave_read_request,
   input  logic                    bus_slave_write_request,
   output logic                    bus_slave_request_finish,
   output logic [PACKET_WIDTH-1:0] bus_slave_output,
   output logic [ARRAY_SIZE-1:0]   west_fifo_rsts,
   output logic [ARRAY_SIZE-1:0]   west_fifo_injects,
   output logic [ARRAY_SIZE-1:0]   west_fifo_bubbles,
   output logic [ARRAY_SIZE-1:0]   north_fifo_rsts,
   output logic [ARRAY_SIZE-1:0]   north_fifo_injects,
   output logic [ARRAY_SIZE-1:0]   north_fifo_bubbles,
   output logic [PACKET_WIDTH-1:0] west_fifo_input_data,
   output logic [PACKET_WIDTH-1:0] north_fifo_input_data,
   output logic                    systolic_rst,
   output logic                    systolic_accumulate_enable,
   output logic                    systolic_read_enable,
   output logic [31:0]             systolic_row_index,
   input  logic [PACKET_WIDTH-1:0] systolic_row_results
);

   localparam int ROW_INDEX_BIT = $clog2(ARRAY_SIZE);

   state_t      state_reg;
   logic [31:0] cycle_reg;
   logic [31:0] cnt_target_reg;
   logic [31:0] row_reg;
   logic        matmul_done_reg;
   logic        move_done_reg;
   logic [7:0]  passes_reg;

   cmd_t                    cmd;
   logic [ROW_INDEX_BIT-1:0] row_sel;
   logic [7:0]              n_eff;
   logic [31:0]             cnt_target_next;
   logic [ARRAY_SIZE-1:0]   lane_onehot;
   logic [ARRAY_SIZE-1:0]   move_onehot;
   logic [ARRAY_SIZE-1:0]   bubble_vec;
   logic [PACKET_WIDTH-1:0] move_data;
   logic [PACKET_WIDTH-1:0] status_word;

   assign cmd             = decode_cmd(bus_slave_read_request, bus_slave_write_request, bus_slave_addr);
   assign row_sel         = bus_slave_addr[ROW_INDEX_BIT+INTRA_ROW_BIT-1:INTRA_ROW_BIT];
   assign n_eff           = clamp_passes(bus_slave_input[7:0], MAX_PASSES);
   assign cnt_target_next = 32'(n_eff) * 32'(ARRAY_SIZE) + 32'(2*ARRAY_SIZE - 2);

   genvar gi;
   generate
      for (gi = 0; gi < ARRAY_SIZE; gi++) begin : g_lane
         assign lane_onehot[gi] = (row_sel == ROW_INDEX_BIT'(gi));
         assign move_onehot[gi] = (row_reg == 32'(gi));
         // Lane gi starts draining once the skewed wavefront reaches it.
         assign bubble_vec[gi]  = (cycle_reg >= 32'(gi));
      end
   endgenerate

`ifdef RELU_ON_MOVE_EN
   move_relu_row #(
      .DATA_WIDTH(DATA_WIDTH),
      .ARRAY_SIZE(ARRAY_SIZE)
   ) u_move_relu_row (
      .row_in (systolic_row_results),
      .row_out(move_data)
   );
`else
   assign move_data = systolic_row_results;
`endif

   always_comb begin
      status_word = '0;
      status_word[STATUS_BUSY_BIT]           = (state_reg != READY);
      status_word[STATUS_MATMUL_DONE_BIT]    = matmul_done_reg;
      status_word[STATUS_MOVE_DONE_BIT]      = move_done_reg;
      status_word[STATUS_PASSES_LSB +: 8]    = passes_reg;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg       <= READY;
         cycle_reg       <= '0;
         cnt_target_reg  <= '0;
         row_reg         <= '0;
         matmul_done_reg <= 1'b0;
         move_done_reg   <= 1'b0;
         passes_reg      <= '0;
      end else begin
         case (state_reg)
            READY: begin
               case (cmd)
                  CMD_MATMUL: begin
                     // A held request after completion only acknowledges; it never restarts.
                     if (matmul_done_reg) begin
                        matmul_done_reg <= 1'b0;
                     end else begin
                        state_reg      <= MATMUL;
                        cycle_reg      <= '0;
                        cnt_target_reg <= cnt_target_next;
                        passes_reg     <= n_eff;
                     end
                  end
                  CMD_MOVE: begin
                     if (move_done_reg) begin
                        move_done_reg <= 1'b0;
                     end else begin
                        state_reg <= MOVE;
                        row_reg   <= '0;
                     end
                  end
                  default: ;
               endcase
            end
            MATMUL: begin
               if (cycle_reg == cnt_target_reg) begin
                  state_reg       <= READY;
                  matmul_done_reg <= 1'b1;
               end else begin
                  cycle_reg <= cycle_reg + 32'd1;
               end
            end
            MOVE: begin
               if (row_reg == 32'(ARRAY_SIZE)) begin
                  state_reg     <= READY;
                  move_done_reg <= 1'b1;
               end else begin
                  row_reg <= row_reg + 32'd1;
               end
            end
            default: state_reg <= READY;
         endcase
      end
   end

   always_comb begin
      bus_slave_request_finish   = 1'b0;
      bus_slave_output           = '0;
      west_fifo_rsts             = '0;
      west_fifo_injects          = '0;
      west_fifo_bubbles          = '0;
      north_fifo_rsts            = '0;
      north_fifo_injects         = '0;
      north_fifo_bubbles         = '0;
      west_fifo_input_data       = '0;
      north_fifo_input_data      = '0;
      systolic_rst               = 1'b0;
      systolic_accumulate_enable = 1'b0;
      systolic_read_enable       = 1'b0;
      systolic_row_index         = '0;

      if (!rst_n) begin
         west_fifo_rsts  = '1;
         north_fifo_rsts = '1;
         systolic_rst    = 1'b1;
      end else begin
         case (state_reg)
            READY: begin
               case (cmd)
                  CMD_LOAD: begin
                     bus_slave_request_finish = 1'b1;
                     if (bus_slave_addr < WEIGHT_FIFO_BASE_ADDR) begin
                        west_fifo_injects    = lane_onehot;
                        west_fifo_input_data = bus_slave_input;
                     end else begin
                        north_fifo_injects    = lane_onehot;
                        north_fifo_input_data = bus_slave_input;
                     end
                  end
                  CMD_SAVE: begin
                     bus_slave_request_finish = 1'b1;
                     systolic_read_enable     = 1'b1;
                     systolic_row_index       = 32'(row_sel);
                     bus_slave_output         = systolic_row_results;
                  end
                  CMD_RESET: begin
                     bus_slave_request_finish = 1'b1;
                     if (bus_slave_addr < WEIGHT_FIFO_BASE_ADDR)
                        west_fifo_rsts = '1;
                     else if (bus_slave_addr < OUTPUT_BUFFER_BASE_ADDR)
                        north_fifo_rsts = '1;
                     else
                        systolic_rst = 1'b1;
                  end
                  CMD_STATUS: begin
                     bus_slave_request_finish = 1'b1;
                     bus_slave_output         = status_word;
                  end
                  CMD_MATMUL: bus_slave_request_finish = matmul_done_reg;
                  CMD_MOVE:   bus_slave_request_finish = move_done_reg;
                  default: ;
               endcase
            end
            MATMUL: begin
               systolic_accumulate_enable = 1'b1;
               west_fifo_bubbles          = bubble_vec;
               north_fifo_bubbles         = bubble_vec;
            end
            MOVE: begin
               if (row_reg < 32'(ARRAY_SIZE)) begin
                  systolic_read_enable = 1'b1;
                  systolic_row_index   = row_reg;
                  west_fifo_injects    = move_onehot;
                  west_fifo_input_data = move_data;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_systolic_tile_controller.sv
// Randomised directed bench for systolic_tile_controller (ARRAY_SIZE=4); honours RELU_ON_MOVE_EN.
module tb_systolic_tile_controller;
   import systolic_tile_controller_pkg::*;

   localparam int DW = 16;
   localparam int AS = 4;
   localparam int MP = 4;
   localparam int PW = AS * DW;

   logic          clk;
   logic          rst_n;
   logic [PW-1:0] bus_in;
   logic [31:0]   addr;
   logic          rd;
   logic          wr;
   logic          finish;
   logic [PW-1:0] bus_out;
   logic [AS-1:0] w_rsts, w_inj, w_bub, n_rsts, n_inj, n_bub;
   logic [PW-1:0] w_data, n_data;
   logic          sys_rst, acc, re;
   logic [31:0]   row_index;
   logic [PW-1:0] row_results;

   logic [PW-1:0] rows [AS];
   int compared = 0;
   int mismatched = 0;

   systolic_tile_controller #(
      .DATA_WIDTH(DW), .ARRAY_SIZE(AS), .MAX_PASSES(MP), .INTRA_ROW_BIT(5), .PACKET_WIDTH(PW)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .bus_slave_input(bus_in), .bus_slave_addr(addr),
      .bus_slave_read_request(rd), .bus_slave_write_request(wr),
      .bus_slave_request_finish(finish), .bus_slave_output(bus_out),
      .west_fifo_rsts(w_rsts), .west_fifo_injects(w_inj), .west_fifo_bubbles(w_bub),
      .north_fifo_rsts(n_rsts), .north_fifo_injects(n_inj), .north_fifo_bubbles(n_bub),
      .west_fifo_input_data(w_data), .north_fifo_input_data(n_data),
      .systolic_rst(sys_rst), .systolic_accumulate_enable(acc),
      .systolic_read_enable(re), .systolic_row_index(row_index),
      .systolic_row_results(row_results)
   );

   always #5 clk = ~clk;

   // Array model: the selected row is visible combinationally.
   always_comb begin
      row_results = '0;
      if (row_index < 32'(AS))
         row_results = rows[row_index[1:0]];
   end

   task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
      compared++;
      assert (obs === exp)
      else begin
         mismatched++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [PW-1:0] move_model(input logic [PW-1:0] p);
      logic [PW-1:0] r;
      logic signed [DW-1:0] e;
      r = p;
`ifdef RELU_ON_MOVE_EN
      for (int k = 0; k < AS; k++) begin
         e = p[k*DW +: DW];
         if (e < 0)
            r[k*DW +: DW] = '0;
      end
`endif
      return r;
   endfunction

   function automatic int eff_n(input int n);
      if (n == 0) return 1;
      if (n > MP) return MP;
      return n;
   endfunction

   function automatic logic [PW-1:0] rand_packet();
      return {$urandom, $urandom};
   endfunction

   task automatic idle();
      rd = 0; wr = 0; addr = '0; bus_in = '0;
   endtask

   task automatic read_status(input logic [PW-1:0] exp);
      @(posedge clk); #1;
      idle(); rd = 1; addr = STATUS_ADDR;
      @(negedge clk);
      chk("status_finish", PW'(finish), PW'(1));
      chk("status_word", bus_out, exp);
      $display("txn STATUS word=%0h", bus_out);
      @(posedge clk); #1; idle();
   endtask

   task automatic do_load(input int bank, input int lane, input logic [PW-1:0] data);
      @(posedge clk); #1;
      idle(); wr = 1;
      addr = (bank == 0 ? INPUT_FIFO_BASE_ADDR : WEIGHT_FIFO_BASE_ADDR) + 32'(lane << 5);
      bus_in = data;
      @(negedge clk);
      chk("load_finish", PW'(finish), PW'(1));
      chk("load_west_inject", PW'(w_inj), bank == 0 ? PW'(1) << lane : PW'(0));
      chk("load_north_inject", PW'(n_inj), bank == 1 ? PW'(1) << lane : PW'(0));
      chk("load_data", bank == 0 ? w_data : n_data, data);
      $display("txn LOAD bank=%0d lane=%0d data=%0h", bank, lane, data);
      @(posedge clk); #1; idle();
   endtask

   task automatic run_matmul(input int n);
      int ne, cnt;
      logic [AS-1:0] exp_b;
      ne = eff_n(n);
      cnt = 0;
      @(posedge clk); #1;
      idle(); wr = 1; addr = OUTPUT_BUFFER_BASE_ADDR; bus_in = PW'(n);
      @(negedge clk);
      chk("mm_start_finish", PW'(finish), PW'(0));
      for (int t = 0; t < 300; t++) begin
         @(negedge clk);
         if (acc) begin
            for (int i = 0; i < AS; i++) exp_b[i] = (cnt >= i);
            chk("mm_west_bubbles", PW'(w_bub), PW'(exp_b));
            chk("mm_north_bubbles", PW'(n_bub), PW'(exp_b));
            cnt++;
         end else if (cnt > 0) begin
            break;
         end
      end
      chk("mm_cycles", PW'(cnt), PW'(ne * AS + 2 * AS - 1));
      chk("mm_done_finish", PW'(finish), PW'(1));
      @(posedge clk); #1;
      @(negedge clk);
      chk("mm_ack_finish", PW'(finish), PW'(0));
      chk("mm_no_restart", PW'(acc), PW'(0));
      idle();
      $display("txn MATMUL n=%0d effective=%0d cycles=%0d", n, ne, cnt);
   endtask

   task automatic run_move();
      int k, busy;
      k = 0; busy = 0;
      @(posedge clk); #1;
      idle(); rd = 1; wr = 1; addr = MOVE_ADDR;
      @(negedge clk);
      chk("mv_start_finish", PW'(finish), PW'(0));
      for (int t = 0; t < 100; t++) begin
         @(negedge clk);
         if (finish) break;
         busy++;
         if (w_inj != '0) begin
            chk("mv_inject", PW'(w_inj), PW'(1) << k);
            chk("mv_row_index", PW'(row_index), PW'(k));
            chk("mv_data", w_data, move_model(rows[k < AS ? k : 0]));
            k++;
         end
      end
      chk("mv_busy_cycles", PW'(busy), PW'(AS + 1));
      chk("mv_rows_injected", PW'(k), PW'(AS));
      chk("mv_done_finish", PW'(finish), PW'(1));
      @(posedge clk); #1;
      @(negedge clk);
      chk("mv_ack_finish", PW'(finish), PW'(0));
      chk("mv_no_restart", PW'(w_inj), PW'(0));
      idle();
      $display("txn MOVE rows=%0d busy=%0d", k, busy);
   endtask

   initial begin
      int cnt, lane;
      logic [PW-1:0] d;
      clk = 0; rst_n = 0; idle();
      for (int r = 0; r < AS; r++) rows[r] = rand_packet();

      @(negedge clk);
      chk("rst_west_rsts", PW'(w_rsts), PW'({AS{1'b1}}));
      chk("rst_north_rsts", PW'(n_rsts), PW'({AS{1'b1}}));
      chk("rst_systolic_rst", PW'(sys_rst), PW'(1));
      chk("rst_acc", PW'(acc), PW'(0));
      @(posedge clk); #1; rst_n = 1;
      @(negedge clk);
      chk("post_rst_rsts", PW'({w_rsts, n_rsts, sys_rst}), PW'(0));
      $display("txn RESET released");
      read_status(PW'(0));

      do_load(1, 2, rand_packet());
      for (int i = 0; i < 5; i++) do_load(int'($urandom_range(0, 1)), int'($urandom_range(0, AS - 1)), rand_packet());

      for (int i = 0; i < AS; i++) begin
         @(posedge clk); #1;
         idle(); rd = 1; addr = OUTPUT_BUFFER_BASE_ADDR + 32'(i << 5);
         @(negedge clk);
         chk("save_finish", PW'(finish), PW'(1));
         chk("save_read_enable", PW'(re), PW'(1));
         chk("save_row_index", PW'(row_index), PW'(i));
         chk("save_data", bus_out, rows[i]);
         $display("txn SAVE row=%0d data=%0h", i, bus_out);
      end
      @(posedge clk); #1; idle();

      for (int tgt = 0; tgt < 3; tgt++) begin
         @(posedge clk); #1;
         idle(); rd = 1; wr = 1;
         addr = (tgt == 0) ? INPUT_FIFO_BASE_ADDR : (tgt == 1) ? WEIGHT_FIFO_BASE_ADDR : OUTPUT_BUFFER_BASE_ADDR;
         @(negedge clk);
         chk("reset_finish", PW'(finish), PW'(1));
         chk("reset_west", PW'(w_rsts), tgt == 0 ? PW'({AS{1'b1}}) : PW'(0));
         chk("reset_north", PW'(n_rsts), tgt == 1 ? PW'({AS{1'b1}}) : PW'(0));
         chk("reset_array", PW'(sys_rst), PW'(tgt == 2));
         $display("txn RESET target=%0d", tgt);
      end
      @(posedge clk); #1; idle();

      run_matmul(2);
      read_status(PW'(2) << 8);
      run_matmul(0);
      read_status(PW'(1) << 8);
      run_matmul(9);
      read_status(PW'(4) << 8);
      run_matmul(int'($urandom_range(1, MP)));

      rows[0] = {rand_packet() >> DW, 16'hFFFD};
      rows[0][DW +: DW] = 16'd5;
      for (int r = 1; r < AS; r++) rows[r] = rand_packet();
      run_move();
      for (int r = 0; r < AS; r++) rows[r] = rand_packet();
      run_move();

      // LOAD held across a MATMUL must wait for READY.
      lane = 1;
      d = rand_packet();
      @(posedge clk); #1;
      idle(); wr = 1; addr = OUTPUT_BUFFER_BASE_ADDR; bus_in = PW'(1);
      @(posedge clk); #1;
      addr = INPUT_FIFO_BASE_ADDR + 32'(lane << 5); bus_in = d;
      cnt = 0;
      for (int t = 0; t < 100; t++) begin
         @(negedge clk);
         if (finish) break;
         chk("ld_busy_inject", PW'({w_inj, n_inj}), PW'(0));
         cnt++;
      end
      chk("ld_wait_cycles", PW'(cnt), PW'(eff_n(1) * AS + 2 * AS - 1));
      chk("ld_late_inject", PW'(w_inj), PW'(1) << lane);
      chk("ld_late_data", w_data, d);
      $display("txn LOAD during MATMUL waited=%0d", cnt);
      read_status((PW'(1) << 8) | PW'(2));
      @(posedge clk); #1;
      idle(); wr = 1; addr = OUTPUT_BUFFER_BASE_ADDR; bus_in = PW'(1);
      @(negedge clk);
      chk("ld_mm_ack_finish", PW'(finish), PW'(1));
      @(posedge clk); #1;
      @(negedge clk);
      chk("ld_mm_no_restart", PW'(acc), PW'(0));
      idle();

      // Reset in the middle of a MATMUL aborts without done.
      @(posedge clk); #1;
      idle(); wr = 1; addr = OUTPUT_BUFFER_BASE_ADDR; bus_in = PW'(2);
      cnt = 0;
      for (int t = 0; t < 50 && cnt < 6; t++) begin
         @(negedge clk);
         if (acc) cnt++;
      end
      chk("abort_reached_cycle5", PW'(cnt), PW'(6));
      rst_n = 0;
      #1;
      chk("abort_rsts", PW'({w_rsts, n_rsts, sys_rst}), PW'({(2 * AS + 1){1'b1}}));
      chk("abort_acc_gated", PW'(acc), PW'(0));
      @(posedge clk); #1;
      rst_n = 1; idle();
      @(negedge clk);
      chk("abort_ready", PW'(acc), PW'(0));
      $display("txn RESET mid-MATMUL");
      read_status(PW'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
